// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU datapath (register file, ALU, decoder,
// writeback). Holds the datapath/register-select widths and the matching
// word/register-address types so every stage agrees on them.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_REGS   = 4;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Four-entry general-purpose register file (R0..R3, all writable, R0 is not
// hardwired to zero). Two combinational read ports feed the ALU operands and
// one clocked write port is driven by writeback. A synchronous active-high
// Reset clears every register and wins over a write on the same edge.
//
// Ports (positional order kept for existing instantiations):
//   RS        in   ADDR_WIDTH  read-port A register select
//   RT        in   ADDR_WIDTH  read-port B register select
//   RD        in   ADDR_WIDTH  write register select
//   WriteData in   DATA_WIDTH  value written to R[RD]
//   ReadRS    out  DATA_WIDTH  R[RS], combinational
//   ReadRT    out  DATA_WIDTH  R[RT], combinational
//   RegWrite  in   1           write enable
//   Clock     in   1           rising edge commits writes and reset
//   Reset     in   1           synchronous, active-high, clears all registers
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT,
  input  logic                  RegWrite,
  input  logic                  Clock,
  input  logic                  Reset
);

  // Depth follows the select width, so every address decodes to a register.
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  // Storage: synchronous clear has priority over the write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (RegWrite) begin
      regs_r[RD] <= WriteData;
    end
  end

  // Read muxes are purely combinational with no write bypass: a read of the
  // register being written shows the old value until the committing edge.
  assign ReadRS = regs_r[RS];
  assign ReadRT = regs_r[RT];

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file. A reference array tracks the register
// contents from the driven stimulus; each read pushes the expected pair onto a
// scoreboard queue, which is popped and compared once the outputs settle.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic [1:0]  rs, rt, rd;
  logic [15:0] write_data;
  logic [15:0] read_rs, read_rt;
  logic        reg_write;
  logic        clock;
  logic        reset;

  register_file dut (
    .RS       (rs),
    .RT       (rt),
    .RD       (rd),
    .WriteData(write_data),
    .ReadRS   (read_rs),
    .ReadRT   (read_rt),
    .RegWrite (reg_write),
    .Clock    (clock),
    .Reset    (reset)
  );

  // Clock generation, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] exp_rs;
    logic [15:0] exp_rt;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [15:0] model [4];
  int          errors = 0;
  int          checks = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the reference model follows the driven controls.
  task automatic do_edge();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    end else if (reg_write) begin
      model[rd] = write_data;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    reg_write  = 1'b1;
    rd         = addr;
    write_data = data;
    do_edge();
    reg_write  = 1'b0;
  endtask

  // Drive read selects, push expectation, then pop and compare after settling.
  task automatic rd_chk(input logic [1:0] a, input logic [1:0] b, input string tag);
    sb_entry_t e;
    rs = a;
    rt = b;
    e.tag    = tag;
    e.exp_rs = model[a];
    e.exp_rt = model[b];
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_eq({e.tag, "_rs"}, read_rs, e.exp_rs);
    check_eq({e.tag, "_rt"}, read_rt, e.exp_rt);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    rs = 2'd0; rt = 2'd0;

    // Reset with a simultaneous write: reset must win.
    reset      = 1'b1;
    reg_write  = 1'b1;
    rd         = 2'd2;
    write_data = 16'hFFFF;
    do_edge();
    reset     = 1'b0;
    reg_write = 1'b0;
    for (int i = 0; i < 4; i++) rd_chk(2'(i), 2'(3 - i), "reset");
    check_eq("reset_r2_const", read_rs, 16'h0000);

    // Basic write/read.
    wr(2'd3, 16'd10);
    wr(2'd1, 16'd13);
    rd_chk(2'd3, 2'd1, "basic");
    check_eq("basic_r3_const", read_rs, 16'd10);
    check_eq("basic_r1_const", read_rt, 16'd13);

    // Write enable off: R0 must stay 0.
    reg_write  = 1'b0;
    rd         = 2'd0;
    write_data = 16'h1234;
    do_edge();
    rd_chk(2'd0, 2'd0, "we_off");
    check_eq("we_off_const", read_rs, 16'h0000);

    // R0 is writable; both ports read the same register.
    wr(2'd0, 16'hA5A5);
    rd_chk(2'd0, 2'd0, "dual_r0");
    check_eq("dual_r0_const", read_rt, 16'hA5A5);

    // Read-during-write: old value before the edge, new value right after.
    wr(2'd2, 16'd5);
    @(negedge clock);
    reg_write  = 1'b1;
    rd         = 2'd2;
    write_data = 16'd9;
    rd_chk(2'd2, 2'd3, "rdw_before");
    check_eq("rdw_before_const", read_rs, 16'd5);
    do_edge();
    reg_write = 1'b0;
    rd_chk(2'd2, 2'd3, "rdw_after");
    check_eq("rdw_after_const", read_rs, 16'd9);

    // Back-to-back writes to the same register: last one wins.
    wr(2'd1, 16'h1111);
    wr(2'd1, 16'h2222);
    rd_chk(2'd1, 2'd0, "b2b");
    check_eq("b2b_const", read_rs, 16'h2222);

    // Sweep: R[i] = 0x1000+i, then every RS/RT pair.
    for (int i = 0; i < 4; i++) wr(2'(i), 16'h1000 + 16'(i));
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        rd_chk(2'(a), 2'(b), $sformatf("sweep_%0d_%0d", a, b));
        check_eq("sweep_const", read_rt, 16'h1000 + 16'(b));
      end
    end

    // Second reset clears everything again.
    reset     = 1'b1;
    reg_write = 1'b1;
    rd        = 2'd3;
    write_data = 16'hBEEF;
    do_edge();
    reset     = 1'b0;
    reg_write = 1'b0;
    for (int i = 0; i < 4; i++) rd_chk(2'(i), 2'(i), "reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file
